fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one sync_fifo write port between N_REQ independent producers. It grants one requester at a time for a burst of up to MAX_BURST beats and muxes that requester's data onto the FIFO write port. It respects the FIFO full flag, so the FIFO is never written while full. It sits directly in front of the FIFO's wr_en/data_in/full ports.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 32, payload width per requester; must match the FIFO data width when the tag feature is off
MAX_BURST, 8, maximum beats per grant (1..256)
IDX_W, 2, requester index width; 2**IDX_W >= N_REQ is required

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester data valid
req_last  input  N_REQ  per-requester end-of-packet; terminates the burst on the beat that transfers it
req_data  input  N_REQ*DATA_WIDTH  flattened payloads; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  N_REQ  per-requester accept; a beat transfers when valid&ready
fifo_full  input  1  FIFO full flag
fifo_wr_en  output  1  FIFO write enable
fifo_data_in  output  FW  FIFO write data; FW=DATA_WIDTH, or DATA_WIDTH+IDX_W with the tag feature
grant_valid  output  1  high while a burst is owned (state BURST)
grant_idx  output  IDX_W  current or last granted requester

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0, grant_valid=0.
- Reset gating: req_ready, fifo_wr_en and fifo_data_in are forced to 0 combinationally while rst is high, in every state.
- State IDLE:
  - req_ready=0, fifo_wr_en=0.
  - If any req_valid is high, select the first set bit searching from rr_ptr upward, wrapping at N_REQ-1 to 0.
  - Register it into grant_idx, clear beat_cnt, go to BURST.
  - Arbitration latency: 1 cycle. No transfer occurs in the decision cycle.
- State BURST:
  - req_ready[grant_idx] = !fifo_full; all other ready bits are 0.
  - Transfer: fifo_wr_en = req_valid[g] & req_ready[g]; fifo_data_in = req_data slice g. This path is combinational, zero latency.
  - Each transfer increments beat_cnt. Stall cycles (fifo_full high, or valid low with no exit) hold beat_cnt.
- Exit BURST to IDLE, with rr_ptr <= (grant_idx==N_REQ-1) ? 0 : grant_idx+1, on:
  - (a) a transfer with beat_cnt==MAX_BURST-1;
  - (b) a transfer with req_last[g]=1;
  - (c) req_valid[g]=0 while fifo_full=0. That cycle carries no transfer.
- Valid low during full: if req_valid[g]=0 while fifo_full=1, the arbiter stays in BURST; the full stall has priority.
- Gap between bursts: exactly 1 idle cycle, because IDLE re-arbitrates. Back-to-back grants to the same requester are allowed only if no other requester is valid.
- Simultaneous requests: the lowest index at or above rr_ptr wins. Requests that arrive mid-burst wait for the burst to end.
- fifo_wr_en is never high while fifo_full=1.
- grant_idx holds its value in IDLE.
- Reset mid-burst: the beat in the reset cycle is dropped (no write). The arbiter is in IDLE after the edge, and requester 0 has highest priority after reset.

Optional Feature:
FIFO_WR_ARB_TAG_EN.
- Defined: fifo_data_in = {grant_idx, req_data slice} with width DATA_WIDTH+IDX_W. This lets the FIFO consumer identify the source of each beat.
- Undefined: fifo_data_in is exactly the DATA_WIDTH payload and no tag logic exists.

Test Plan:
1. Single requester (N_REQ=4, MAX_BURST=8): req 1 valid for 3 beats, then low -> grant_valid rises 1 cycle after valid; exactly 3 fifo_wr_en pulses; returns to IDLE; next search starts at 2.
2. All 4 requesters valid continuously, no last -> grants 0,1,2,3,0 in that order, 8 writes each, one idle cycle between bursts.
3. Req 0 in a burst; fifo_full high for 5 cycles after beat 3 -> req_ready and fifo_wr_en low for those 5 cycles; beat_cnt held at 3; 5 further beats complete the burst (8 total).
4. Req 2 asserts req_last on its 2nd beat while req 3 is valid -> exactly 2 writes from req 2, then grant_idx=3 after one IDLE cycle.
5. rst pulsed for 1 cycle during beat 4 of a req 2 burst -> fifo_wr_en=0 in the reset cycle; grant_valid=0 after the edge; with req 0 and req 2 both valid afterwards, req 0 is granted first.
6. With FIFO_WR_ARB_TAG_EN defined, req 3 data 0xDEADBEEF -> fifo_data_in = {2'b11, 32'hDEADBEEF}. Undefined -> fifo_data_in = 32'hDEADBEEF.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the fifo_wr_arbiter handshake: requester side, FIFO write side and grant status.
// master: the arbiter. slave: requesters, FIFO and observers.
// Define FIFO_WR_ARB_TAG_EN to widen fifo_data_in by IDX_W bits for the source tag.
interface fifo_wr_arbiter_if #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_W      = 2
);
`ifdef FIFO_WR_ARB_TAG_EN
   localparam int unsigned FW = DATA_WIDTH + IDX_W;
`else
   localparam int unsigned FW = DATA_WIDTH;
`endif

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_last;
   logic [N_REQ*DATA_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]            req_ready;
   logic                        fifo_full;
   logic                        fifo_wr_en;
   logic [FW-1:0]               fifo_data_in;
   logic                        grant_valid;
   logic [IDX_W-1:0]            grant_idx;

   modport master (
      input  req_valid, req_last, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_idx
   );

   modport slave (
      output req_valid, req_last, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_idx
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers, one burst of up to
// MAX_BURST beats per grant. The write path is combinational from the granted requester.
// Optional: define FIFO_WR_ARB_TAG_EN to prepend grant_idx to every written beat.
module fifo_wr_arbiter #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 8,
   parameter int unsigned IDX_W      = 2
) (
   input logic               clk,
   input logic               rst,
   fifo_wr_arbiter_if.master bus
);
   localparam int unsigned      CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] LastBeat = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(N_REQ - 1);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StBurst = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic                  found;
   logic [IDX_W-1:0]      pick;
   logic [IDX_W-1:0]      cand_idx;
   int unsigned           cand;
   logic                  in_burst, valid_g, last_g, xfer, done;
   logic [IDX_W-1:0]      next_ptr;
   logic [DATA_WIDTH-1:0] slices [N_REQ];

   // Unpack the flattened payload bus so the granted slice is a plain array select.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         slices[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      found    = 1'b0;
      pick     = rr_ptr_q;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand     = (32'(rr_ptr_q) + i) % N_REQ;
         cand_idx = IDX_W'(cand);
         if (!found && bus.req_valid[cand_idx]) begin
            found = 1'b1;
            pick  = cand_idx;
         end
      end
   end

   // Burst bookkeeping for the current owner; reset kills the beat in flight.
   always_comb begin
      in_burst = (state_q == StBurst);
      valid_g  = bus.req_valid[grant_idx_q];
      last_g   = bus.req_last[grant_idx_q];
      xfer     = in_burst && valid_g && !bus.fifo_full && !rst;
      // A full stall takes priority over the owner dropping valid.
      done     = in_burst && ((xfer && (beat_cnt_q == LastBeat || last_g)) ||
                              (!valid_g && !bus.fifo_full));
      next_ptr = (grant_idx_q == LastIdx) ? '0 : grant_idx_q + IDX_W'(1);
   end

   // Next-state: arbitrate in IDLE, count beats and detect burst end in BURST.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_idx_d = grant_idx_q;
      beat_cnt_d  = beat_cnt_q;
      if (!in_burst) begin
         if (found) begin
            grant_idx_d = pick;
            beat_cnt_d  = '0;
            state_d     = StBurst;
         end
      end else begin
         if (xfer) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
         end
         if (done) begin
            state_d  = StIdle;
            rr_ptr_d = next_ptr;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         grant_idx_q <= '0;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_idx_q <= grant_idx_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   // Outputs: ready only to the owner while the FIFO has room; all gated off during reset.
   always_comb begin
      bus.req_ready = '0;
      if (in_burst && !bus.fifo_full && !rst) begin
         bus.req_ready[grant_idx_q] = 1'b1;
      end
      bus.fifo_wr_en  = xfer;
      bus.grant_valid = in_burst;
      bus.grant_idx   = grant_idx_q;
`ifdef FIFO_WR_ARB_TAG_EN
      bus.fifo_data_in = rst ? '0 : {grant_idx_q, slices[grant_idx_q]};
`else
      bus.fifo_data_in = rst ? '0 : slices[grant_idx_q];
`endif
   end
endmodule
